// File: rtl/binary_tower_32b_div_alpha_seq_if.sv
// rtl/binary_tower_32b_div_alpha_seq_if.sv - job/result stream bundle for the divide-by-alpha engine
interface binary_tower_32b_div_alpha_seq_if #(
  parameter int K_W = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [31:0]    in_a;
  logic [K_W-1:0] in_k;
  logic           out_valid;
  logic           out_ready;
  logic [31:0]    out_r;
  logic           busy;

  modport master (
    output in_valid, in_a, in_k, out_ready,
    input  in_ready, out_valid, out_r, busy
  );

  modport slave (
    input  in_valid, in_a, in_k, out_ready,
    output in_ready, out_valid, out_r, busy
  );
endinterface

// File: rtl/binary_tower_32b_div_alpha_seq.sv
// rtl/binary_tower_32b_div_alpha_seq.sv - sequential a * alpha^(-k) in the 32-bit binary tower field
module binary_tower_32b_div_alpha_seq #(
  parameter int K_W = 8
) (
  input  logic                              ap_clk,
  input  logic                              ap_rst_n,
  binary_tower_32b_div_alpha_seq_if.slave   s
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [31:0]    acc, acc_nxt;
  logic [K_W-1:0] cnt, cnt_nxt;

  // Multiply-by-alpha at each tower level: {x1,x0} -> {x0 ^ MA(x1), x1}.
  function automatic logic [1:0] ma2(input logic [1:0] x);
    return {x[0] ^ x[1], x[1]};
  endfunction

  function automatic logic [3:0] ma4(input logic [3:0] x);
    return {x[1:0] ^ ma2(x[3:2]), x[3:2]};
  endfunction

  function automatic logic [7:0] ma8(input logic [7:0] x);
    return {x[3:0] ^ ma4(x[7:4]), x[7:4]};
  endfunction

  function automatic logic [15:0] ma16(input logic [15:0] x);
    return {x[7:0] ^ ma8(x[15:8]), x[15:8]};
  endfunction

  // One inverse-alpha step; undoes ma32 exactly.
  function automatic logic [31:0] inv_alpha(input logic [31:0] r);
    return {r[15:0], r[31:16] ^ ma16(r[15:0])};
  endfunction

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (s.in_valid) begin
          acc_nxt   = s.in_a;
          cnt_nxt   = s.in_k;
          state_nxt = (s.in_k == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // RUN is only entered with cnt >= 1, so the decrement cannot wrap.
        acc_nxt = inv_alpha(acc);
        cnt_nxt = cnt - K_W'(1);
        if (cnt == K_W'(1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (s.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign s.in_ready  = (state == IDLE);
  assign s.out_valid = (state == DONE);
  assign s.out_r     = acc;
  assign s.busy      = (state == RUN) || (state == DONE);

endmodule
